// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC sequencer: sequential, relative-branch and absolute-jump next-PC selection with start/done handshake.
// Latency: every output is a flop; an input is reflected on the outputs one clock edge later.
// Backpressure: stall holds the PC for one cycle; in RUN the cycle counter advances on every edge regardless.
module fetch_pc_unit #(
    parameter int                  PC_WIDTH     = 10,
    parameter int                  OFFSET_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] START_ADDR   = '0,
    parameter int                  COUNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    stall,
    input  logic                    halt,
    input  logic                    branch_taken,
    input  logic [OFFSET_WIDTH-1:0] branch_offset,
    input  logic                    jump,
    input  logic [PC_WIDTH-1:0]     jump_target,
    output logic [PC_WIDTH-1:0]     pc,
    output logic                    running,
    output logic                    done,
    output logic [COUNT_WIDTH-1:0]  cycle_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]             state;
    logic [PC_WIDTH-1:0]    offset_ext;
    logic [PC_WIDTH-1:0]    pc_next;
    logic [COUNT_WIDTH-1:0] count_next;

    // Offset is sign-extended first so the add wraps modulo 2^PC_WIDTH in both directions.
    assign offset_ext = PC_WIDTH'(signed'(branch_offset));

    always_comb begin
        pc_next = pc + PC_WIDTH'(1);
        if (halt || stall) begin
            pc_next = pc;
        end else if (jump) begin
            pc_next = jump_target;
        end else if (branch_taken) begin
            pc_next = pc + offset_ext;
        end
    end

    assign count_next = (cycle_count == {COUNT_WIDTH{1'b1}}) ? cycle_count
                                                              : cycle_count + COUNT_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            pc          <= START_ADDR;
            cycle_count <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state       <= S_RUN;
                        pc          <= START_ADDR;
                        cycle_count <= '0;
                    end
                end
                S_RUN: begin
                    pc          <= pc_next;
                    cycle_count <= count_next;
                    if (halt) begin
                        state <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign running = (state == S_RUN);
    assign done    = (state == S_DONE);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed table of per-edge vectors against hand-computed PC/state/count, plus long-run saturation and halt sequences.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, stall, halt, branch_taken, jump;
    logic [7:0]  branch_offset;
    logic [9:0]  jump_target;
    logic [9:0]  pc, pc4;
    logic        running, done, running4, done4;
    logic [15:0] cycle_count;
    logic [3:0]  cycle_count4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_pc_unit dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stall(stall), .halt(halt),
        .branch_taken(branch_taken), .branch_offset(branch_offset), .jump(jump),
        .jump_target(jump_target), .pc(pc), .running(running), .done(done),
        .cycle_count(cycle_count)
    );

    fetch_pc_unit #(.COUNT_WIDTH(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .start(start), .stall(stall), .halt(halt),
        .branch_taken(branch_taken), .branch_offset(branch_offset), .jump(jump),
        .jump_target(jump_target), .pc(pc4), .running(running4), .done(done4),
        .cycle_count(cycle_count4)
    );

    typedef struct {
        logic        rst_n, start, stall, halt, jump, br;
        logic [9:0]  tgt;
        logic [7:0]  off;
        logic [9:0]  e_pc;
        logic        e_run, e_done;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic rst_n, input logic st, input logic sl, input logic hl,
                                input logic jp, input logic [9:0] tgt, input logic br,
                                input logic [7:0] off, input logic [9:0] e_pc,
                                input logic e_run, input logic e_done, input logic [15:0] e_cnt);
        vec_t v;
        v.rst_n = rst_n; v.start = st; v.stall = sl; v.halt = hl; v.jump = jp; v.tgt = tgt;
        v.br = br; v.off = off; v.e_pc = e_pc; v.e_run = e_run; v.e_done = e_done; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        @(negedge clk);
        reset_n = v.rst_n; start = v.start; stall = v.stall; halt = v.halt;
        jump = v.jump; jump_target = v.tgt; branch_taken = v.br; branch_offset = v.off;
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input vec_t v, input int idx);
        logic [15:0] c4;
        c4 = (v.e_cnt > 16'd15) ? 16'd15 : v.e_cnt;
        check("pc", idx, 32'(pc), 32'(v.e_pc));
        check("running", idx, 32'(running), 32'(v.e_run));
        check("done", idx, 32'(done), 32'(v.e_done));
        check("cycle_count", idx, 32'(cycle_count), 32'(v.e_cnt));
        check("cycle_count_w4", idx, 32'(cycle_count4), 32'(c4));
    endtask

    initial begin
        // rst_n st sl hl jp tgt      br off     e_pc    run done cnt
        vq.push_back(mk(0, 0, 0, 0, 0, 10'h000, 0, 8'h00, 10'h000, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 10'h000, 0, 8'h00, 10'h000, 0, 0, 0));
        vq.push_back(mk(1, 0, 1, 1, 1, 10'h055, 1, 8'h07, 10'h000, 0, 0, 0));  // IDLE ignores controls
        vq.push_back(mk(1, 1, 0, 0, 0, 10'h000, 0, 8'h00, 10'h000, 1, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 0, 10'h000, 0, 8'h00, 10'h001, 1, 0, 1));
        vq.push_back(mk(1, 0, 0, 0, 0, 10'h000, 0, 8'h00, 10'h002, 1, 0, 2));
        vq.push_back(mk(1, 0, 0, 0, 0, 10'h000, 0, 8'h00, 10'h003, 1, 0, 3));
        vq.push_back(mk(1, 1, 0, 0, 0, 10'h000, 0, 8'h00, 10'h004, 1, 0, 4));  // start ignored in RUN
        vq.push_back(mk(1, 0, 0, 0, 0, 10'h000, 0, 8'h00, 10'h005, 1, 0, 5));
        vq.push_back(mk(1, 0, 0, 0, 0, 10'h000, 1, 8'hFD, 10'h002, 1, 0, 6));
        vq.push_back(mk(1, 0, 0, 0, 0, 10'h000, 1, 8'h04, 10'h006, 1, 0, 7));
        vq.push_back(mk(1, 0, 0, 0, 1, 10'h001, 0, 8'h00, 10'h001, 1, 0, 8));
        vq.push_back(mk(1, 0, 0, 0, 0, 10'h000, 1, 8'hFC, 10'h3FD, 1, 0, 9));
        vq.push_back(mk(1, 0, 0, 0, 1, 10'h007, 0, 8'h00, 10'h007, 1, 0, 10));
        vq.push_back(mk(1, 0, 0, 0, 1, 10'h100, 1, 8'h02, 10'h100, 1, 0, 11));
        vq.push_back(mk(1, 0, 1, 0, 1, 10'h200, 0, 8'h00, 10'h100, 1, 0, 12));
        vq.push_back(mk(1, 0, 1, 0, 0, 10'h000, 1, 8'h05, 10'h100, 1, 0, 13));
        vq.push_back(mk(1, 0, 0, 0, 0, 10'h000, 0, 8'h00, 10'h101, 1, 0, 14));
        vq.push_back(mk(1, 0, 0, 0, 1, 10'h3FE, 0, 8'h00, 10'h3FE, 1, 0, 15));
        vq.push_back(mk(1, 0, 0, 0, 0, 10'h000, 0, 8'h00, 10'h3FF, 1, 0, 16));
        vq.push_back(mk(1, 0, 0, 0, 0, 10'h000, 0, 8'h00, 10'h000, 1, 0, 17));
        vq.push_back(mk(1, 0, 0, 0, 1, 10'h3FE, 0, 8'h00, 10'h3FE, 1, 0, 18));
        vq.push_back(mk(1, 0, 0, 0, 0, 10'h000, 1, 8'h04, 10'h002, 1, 0, 19));
        vq.push_back(mk(1, 0, 0, 0, 1, 10'h020, 0, 8'h00, 10'h020, 1, 0, 20));
        vq.push_back(mk(1, 0, 1, 1, 1, 10'h099, 0, 8'h00, 10'h020, 0, 1, 21));  // halt beats stall
        vq.push_back(mk(1, 0, 0, 0, 0, 10'h000, 0, 8'h00, 10'h020, 0, 1, 21));
        vq.push_back(mk(1, 0, 0, 0, 1, 10'h123, 1, 8'h10, 10'h020, 0, 1, 21));
        vq.push_back(mk(1, 0, 1, 1, 0, 10'h000, 0, 8'h00, 10'h020, 0, 1, 21));
        vq.push_back(mk(1, 0, 0, 0, 0, 10'h000, 0, 8'h00, 10'h020, 0, 1, 21));
        vq.push_back(mk(1, 0, 0, 0, 0, 10'h000, 0, 8'h00, 10'h020, 0, 1, 21));
        vq.push_back(mk(1, 1, 0, 0, 0, 10'h000, 0, 8'h00, 10'h000, 1, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 0, 10'h000, 0, 8'h00, 10'h001, 1, 0, 1));
        vq.push_back(mk(1, 0, 0, 0, 1, 10'h055, 0, 8'h00, 10'h055, 1, 0, 2));
        vq.push_back(mk(0, 1, 0, 0, 1, 10'h0AA, 0, 8'h00, 10'h000, 0, 0, 0));  // reset beats everything
        vq.push_back(mk(1, 0, 0, 1, 0, 10'h000, 0, 8'h00, 10'h000, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 1, 10'h0AA, 1, 8'h03, 10'h000, 0, 0, 0));

        reset_n = 1'b0; start = 0; stall = 0; halt = 0; jump = 0; branch_taken = 0;
        jump_target = '0; branch_offset = '0;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i]);
            check_vec(vq[i], i);
        end

        // Long free run from a fresh start: PC tracks edges, narrow counter pins at 15.
        begin
            vec_t v;
            v = mk(1, 1, 0, 0, 0, 10'h000, 0, 8'h00, 10'h000, 1, 0, 0);
            drive(v);
            v.start = 0;
            for (int n = 1; n <= 40; n++) begin
                drive(v);
            end
            check("long_pc", 100, 32'(pc), 32'd40);
            check("long_cnt", 100, 32'(cycle_count), 32'd40);
            check("long_cnt_w4", 100, 32'(cycle_count4), 32'd15);

            // halt, then bounded wait for done; count includes the halt cycle
            v.halt = 1;
            drive(v);
            v.halt = 0;
            begin
                int budget = 10;
                while (!done && budget > 0) begin
                    drive(v);
                    budget--;
                end
                check("halt_done_seen", 101, 32'(done), 32'd1);
            end
            check("halt_pc", 101, 32'(pc), 32'd40);
            check("halt_cnt", 101, 32'(cycle_count), 32'd41);
            check("halt_running", 101, 32'(running), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
